// File: rtl/rr_handshake_arbiter_pkg.sv
// Shared types and helpers for the round-robin handshake arbiter.
// Default widths match the PE-lane front end of the shared datapath.
package rr_handshake_arbiter_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_ID_W    = $clog2(DEF_NUM_REQ);

  typedef logic [DEF_DATA_W-1:0] beat_t;
  typedef logic [DEF_ID_W-1:0]   arb_id_t;

  // Next round-robin slot with an explicit wrap, so non-power-of-2 counts work
  function automatic int wrap_inc(input int idx, input int n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_handshake_arbiter_if.sv
// Requester-side and downstream valid/ready bundle of the arbiter.
// master drives requests and out_rdy; slave is the arbiter itself.
interface rr_handshake_arbiter_if
  import rr_handshake_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ID_W    = $clog2(NUM_REQ)
);

  logic [NUM_REQ-1:0]        req_vld;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_rdy;
  logic                      out_vld;
  logic [DATA_W-1:0]         out_data;
  logic                      out_last;
  logic [ID_W-1:0]           out_id;
  logic                      out_rdy;
  logic                      locked;

  modport master (
    output req_vld, req_last, req_data, out_rdy,
    input  req_rdy, out_vld, out_data, out_last, out_id, locked
  );

  modport slave (
    input  req_vld, req_last, req_data, out_rdy,
    output req_rdy, out_vld, out_data, out_last, out_id, locked
  );

endinterface

// File: rtl/rr_priority_pick.sv
// Rotating priority encoder: first set bit of req starting at ptr.
// Purely combinational; shared by the arbiters in the datapath.
module rr_priority_pick #(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [ID_W-1:0] grant,
  output logic            grant_vld
);

  int idx;

  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    idx       = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!grant_vld && req[idx]) begin
        grant_vld = 1'b1;
        grant     = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/rr_handshake_arbiter.sv
// Packet-aware N-to-1 round-robin arbiter with a registered output beat.
// Grant stays on one requester from first beat until its last beat.
module rr_handshake_arbiter
  import rr_handshake_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input logic                 clk,
  input logic                 rst,
  rr_handshake_arbiter_if.slave bus
);

  logic [NUM_REQ-1:0][DATA_W-1:0] data_v;
  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] mask;
  logic [NUM_REQ-1:0] rdy;
  logic [ID_W-1:0]    grant;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    lock_id;
  logic [ID_W-1:0]    out_id;
  logic [DATA_W-1:0]  out_data;
  logic               grant_vld;
  logic               load_en;
  logic               xfer;
  logic               out_vld;
  logic               out_last;
  logic               locked;

  assign data_v  = bus.req_data;
  assign load_en = bus.out_rdy | ~out_vld;

  always_comb begin
    elig = '0;
    if (locked) elig[lock_id] = 1'b1;
    else        elig = '1;
  end

  assign mask = bus.req_vld & elig;

  rr_priority_pick #(
    .N    (NUM_REQ),
    .ID_W (ID_W)
  ) u_pick (
    .req       (mask),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_vld (grant_vld)
  );

  always_comb begin
    rdy = '0;
    if (load_en && grant_vld && !rst) rdy[grant] = 1'b1;
  end

  assign xfer = |(bus.req_vld & rdy);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld  <= 1'b0;
      out_data <= '0;
      out_last <= 1'b0;
      out_id   <= '0;
      locked   <= 1'b0;
      lock_id  <= '0;
      rr_ptr   <= '0;
    end else if (xfer) begin
      out_vld  <= 1'b1;
      out_data <= data_v[grant];
      out_last <= bus.req_last[grant];
      out_id   <= grant;
      if (!bus.req_last[grant]) begin
        locked  <= 1'b1;
        lock_id <= grant;
      end else begin
        locked  <= 1'b0;
        rr_ptr  <= ID_W'(wrap_inc(int'(grant), NUM_REQ));
      end
    end else if (bus.out_rdy) begin
      out_vld <= 1'b0;
    end
  end

  assign bus.req_rdy  = rdy;
  assign bus.out_vld  = out_vld;
  assign bus.out_data = out_data;
  assign bus.out_last = out_last;
  assign bus.out_id   = out_id;
  assign bus.locked   = locked;

  a_rdy_onehot: assert property (@(posedge clk) $onehot0(rdy));

  a_out_hold: assert property (@(posedge clk) disable iff (rst)
    (out_vld && !bus.out_rdy) |=>
      (out_vld && $stable(out_data) && $stable(out_last) && $stable(out_id)));

  a_lock_grant: assert property (@(posedge clk) disable iff (rst)
    locked |-> (!grant_vld || grant == lock_id));

  // Requesters must not change a pending beat until it is taken
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_req_hold
    a_req_hold: assert property (@(posedge clk) disable iff (rst)
      (bus.req_vld[i] && !rdy[i]) |=>
        (!bus.req_vld[i] || ($stable(data_v[i]) && $stable(bus.req_last[i]))));
  end

endmodule
